// File: rtl/triangle_assemble.sv
// Assembles a vertex stream into triangles (with primitive restart) and queues
// them in a small FIFO for a downstream consumer with ready/valid handshake.
module triangle_assemble #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] RESTART_ID = 16'hFFFF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  input  logic [15:0]           vertex_id_in,
  input  logic [2:0][31:0]      vertex_in,
  input  logic [11:0]           color_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [2:0][15:0]      vertex_ids_out,
  output logic [2:0][2:0][31:0] vertices_out,
  output logic [2:0][11:0]      colors_out,
  output logic                  overflow_out,
  output logic [15:0]           tri_count_out
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDX0 = 2'd0,
    S_IDX1 = 2'd1,
    S_IDX2 = 2'd2
  } idx_t;

  idx_t r_idx;
  idx_t w_idx_nxt;

  logic             w_slot0_we;
  logic             w_slot1_we;
  logic             w_push;

  logic [15:0]      r_slot_id  [2];
  logic [2:0][31:0] r_slot_pos [2];
  logic [11:0]      r_slot_col [2];

  logic [2:0][15:0]      r_mem_id  [FIFO_DEPTH];
  logic [2:0][2:0][31:0] r_mem_pos [FIFO_DEPTH];
  logic [2:0][11:0]      r_mem_col [FIFO_DEPTH];

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;

  logic             r_overflow;
  logic [15:0]      r_tri_count;

  logic [2:0][15:0]      w_tri_id;
  logic [2:0][2:0][31:0] w_tri_pos;
  logic [2:0][11:0]      w_tri_col;

  // Assembly index state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_idx <= S_IDX0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_idx_nxt  = r_idx;
    w_slot0_we = 1'b0;
    w_slot1_we = 1'b0;
    w_push     = 1'b0;
    if (valid_in) begin
      if (vertex_id_in == RESTART_ID) begin
        w_idx_nxt = S_IDX0;
      end else begin
        case (r_idx)
          S_IDX0: begin
            w_slot0_we = 1'b1;
            w_idx_nxt  = S_IDX1;
          end
          S_IDX1: begin
            w_slot1_we = 1'b1;
            w_idx_nxt  = S_IDX2;
          end
          S_IDX2: begin
            w_push    = 1'b1;
            w_idx_nxt = S_IDX0;
          end
          default: w_idx_nxt = S_IDX0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_slot_id[i]  <= '0;
        r_slot_pos[i] <= '0;
        r_slot_col[i] <= '0;
      end
    end else begin
      if (w_slot0_we) begin
        r_slot_id[0]  <= vertex_id_in;
        r_slot_pos[0] <= vertex_in;
        r_slot_col[0] <= color_in;
      end
      if (w_slot1_we) begin
        r_slot_id[1]  <= vertex_id_in;
        r_slot_pos[1] <= vertex_in;
        r_slot_col[1] <= color_in;
      end
    end
  end

  // Entry 0 is the earliest vertex; the third vertex comes straight from the inputs
  always_comb begin
    w_tri_id[0]  = r_slot_id[0];
    w_tri_id[1]  = r_slot_id[1];
    w_tri_id[2]  = vertex_id_in;
    w_tri_pos[0] = r_slot_pos[0];
    w_tri_pos[1] = r_slot_pos[1];
    w_tri_pos[2] = vertex_in;
    w_tri_col[0] = r_slot_col[0];
    w_tri_col[1] = r_slot_col[1];
    w_tri_col[2] = color_in;
  end

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop    = !w_empty && ready_in;
  // A pop on a full FIFO frees the head slot at the same edge the push writes it
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_id[i]  <= '0;
        r_mem_pos[i] <= '0;
        r_mem_col[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem_id[r_wr_ptr[AW-1:0]]  <= w_tri_id;
      r_mem_pos[r_wr_ptr[AW-1:0]] <= w_tri_pos;
      r_mem_col[r_wr_ptr[AW-1:0]] <= w_tri_col;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_tri_count <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_tri_count <= r_tri_count + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign valid_out      = !w_empty;
  assign vertex_ids_out = r_mem_id[r_rd_ptr[AW-1:0]];
  assign vertices_out   = r_mem_pos[r_rd_ptr[AW-1:0]];
  assign colors_out     = r_mem_col[r_rd_ptr[AW-1:0]];
  assign overflow_out   = r_overflow;
  assign tri_count_out  = r_tri_count;

endmodule

// File: tb/tb_triangle_assemble.sv
// Directed bench for triangle_assemble: table of single-cycle vectors plus
// hand-written sequences for overflow, full push/pop, and mid-stream reset.
module tb_triangle_assemble;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  valid_in;
  logic [15:0]           vertex_id_in;
  logic [2:0][31:0]      vertex_in;
  logic [11:0]           color_in;
  logic                  ready_in;
  logic                  valid_out;
  logic [2:0][15:0]      vertex_ids_out;
  logic [2:0][2:0][31:0] vertices_out;
  logic [2:0][11:0]      colors_out;
  logic                  overflow_out;
  logic [15:0]           tri_count_out;

  int n_cmp = 0;
  int n_err = 0;

  triangle_assemble #(.FIFO_DEPTH(4), .RESTART_ID(16'hFFFF)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .vertex_id_in   (vertex_id_in),
    .vertex_in      (vertex_in),
    .color_in       (color_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .vertex_ids_out (vertex_ids_out),
    .vertices_out   (vertices_out),
    .colors_out     (colors_out),
    .overflow_out   (overflow_out),
    .tri_count_out  (tri_count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [2:0][31:0] pos_of(input logic [15:0] id);
    logic [2:0][31:0] p;
    for (int j = 0; j < 3; j++) p[j] = {16'(j + 1) * 16'h1111, id};
    return p;
  endfunction

  function automatic logic [11:0] col_of(input logic [15:0] id);
    return id[11:0] ^ 12'h5A5;
  endfunction

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c);
    logic [2:0][15:0]      e_id;
    logic [2:0][2:0][31:0] e_pos;
    logic [2:0][11:0]      e_col;
    e_id  = {c, b, a};
    e_pos = {pos_of(c), pos_of(b), pos_of(a)};
    e_col = {col_of(c), col_of(b), col_of(a)};
    chk({name, ".valid"}, 288'(valid_out), 288'(1'b1));
    chk({name, ".ids"}, 288'(vertex_ids_out), 288'(e_id));
    chk({name, ".pos"}, 288'(vertices_out), 288'(e_pos));
    chk({name, ".col"}, 288'(colors_out), 288'(e_col));
  endtask

  task automatic send(input logic v, input logic [15:0] id, input logic rdy);
    valid_in     = v;
    vertex_id_in = id;
    vertex_in    = pos_of(id);
    color_in     = col_of(id);
    ready_in     = rdy;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    ready_in = 1'b0;
    rst_in   = 1'b0;
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] id;
    logic        rdy;
    logic        exp_v;
    logic [15:0] e0, e1, e2;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [15:0] id, input logic rdy, input logic ev,
                     input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                     input logic [15:0] cnt);
    vec_t r;
    r = '{v: v, id: id, rdy: rdy, exp_v: ev, e0: e0, e1: e1, e2: e2, exp_cnt: cnt};
    vecs.push_back(r);
  endtask

  initial begin
    // basic assembly, one-cycle visibility with ready=1
    add(1, 16'd0,     1, 0, 0, 0, 0, 16'd0);
    add(1, 16'd1,     1, 0, 0, 0, 0, 16'd0);
    add(1, 16'd2,     1, 1, 0, 1, 2, 16'd1);
    add(0, 16'd2,     1, 0, 0, 0, 0, 16'd1);
    // restart discards the partial 5,6; idle cycle in the middle is ignored
    add(1, 16'd5,     1, 0, 0, 0, 0, 16'd1);
    add(1, 16'd6,     1, 0, 0, 0, 0, 16'd1);
    add(1, 16'hFFFF,  1, 0, 0, 0, 0, 16'd1);
    add(1, 16'd7,     1, 0, 0, 0, 0, 16'd1);
    add(0, 16'd3,     1, 0, 0, 0, 0, 16'd1);
    add(1, 16'd8,     1, 0, 0, 0, 0, 16'd1);
    add(1, 16'd9,     1, 1, 7, 8, 9, 16'd2);
    add(0, 16'd9,     1, 0, 0, 0, 0, 16'd2);
    // backpressure holds the head stable
    add(1, 16'd20,    0, 0, 0, 0, 0, 16'd2);
    add(1, 16'd21,    0, 0, 0, 0, 0, 16'd2);
    add(1, 16'd22,    0, 1, 20, 21, 22, 16'd3);
    add(0, 16'd0,     0, 1, 20, 21, 22, 16'd3);
    add(0, 16'd0,     1, 0, 0, 0, 0, 16'd3);
    // restart right at index 2
    add(1, 16'd30,    1, 0, 0, 0, 0, 16'd3);
    add(1, 16'd31,    1, 0, 0, 0, 0, 16'd3);
    add(1, 16'hFFFF,  1, 0, 0, 0, 0, 16'd3);
    add(1, 16'd32,    1, 0, 0, 0, 0, 16'd3);
    add(1, 16'd33,    1, 0, 0, 0, 0, 16'd3);
    add(1, 16'd34,    1, 1, 32, 33, 34, 16'd4);
    add(0, 16'd0,     1, 0, 0, 0, 0, 16'd4);

    valid_in     = 1'b0;
    vertex_id_in = 16'h1234;
    vertex_in    = pos_of(16'h1234);
    color_in     = 12'hABC;
    ready_in     = 1'b1;
    rst_in       = 1'b0;
    #2;
    chk("rst.valid", 288'(valid_out), 288'(1'b0));
    chk("rst.ovf", 288'(overflow_out), 288'(1'b0));
    chk("rst.cnt", 288'(tri_count_out), 288'(16'd0));
    chk("rst.ids", 288'(vertex_ids_out), 288'(0));
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].v, vecs[i].id, vecs[i].rdy);
      chk($sformatf("vec%0d.valid", i), 288'(valid_out), 288'(vecs[i].exp_v));
      chk($sformatf("vec%0d.cnt", i), 288'(tri_count_out), 288'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.ovf", i), 288'(overflow_out), 288'(1'b0));
      if (vecs[i].exp_v)
        chk_head($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
    end

    // overflow: 5 triangles into a 4-deep FIFO with no pops
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 16'(i), 1'b0);
      if (i == 11) begin
        chk("ovf.cnt_at_full", 288'(tri_count_out), 288'(16'd4));
        chk("ovf.not_yet", 288'(overflow_out), 288'(1'b0));
      end
    end
    chk("ovf.flag", 288'(overflow_out), 288'(1'b1));
    chk("ovf.cnt", 288'(tri_count_out), 288'(16'd4));
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("ovf.drain%0d", k), 16'(3 * k), 16'(3 * k + 1), 16'(3 * k + 2));
      send(1'b0, 16'd0, 1'b1);
    end
    chk("ovf.empty", 288'(valid_out), 288'(1'b0));
    chk("ovf.sticky", 288'(overflow_out), 288'(1'b1));
    chk("ovf.cnt_end", 288'(tri_count_out), 288'(16'd4));

    // full FIFO: push and pop on the same edge
    do_reset();
    for (int i = 0; i < 14; i++) send(1'b1, 16'(i), 1'b0);
    chk("full.cnt_pre", 288'(tri_count_out), 288'(16'd4));
    send(1'b1, 16'd14, 1'b1);
    chk("full.ovf", 288'(overflow_out), 288'(1'b0));
    chk("full.cnt", 288'(tri_count_out), 288'(16'd5));
    for (int k = 1; k < 5; k++) begin
      chk_head($sformatf("full.drain%0d", k), 16'(3 * k), 16'(3 * k + 1), 16'(3 * k + 2));
      send(1'b0, 16'd0, 1'b1);
    end
    chk("full.empty", 288'(valid_out), 288'(1'b0));

    // single entry: push and pop on the same edge keeps occupancy at 1
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 16'(i), 1'b0);
    chk_head("one.pre", 16'd0, 16'd1, 16'd2);
    send(1'b1, 16'd5, 1'b1);
    chk_head("one.post", 16'd3, 16'd4, 16'd5);
    chk("one.cnt", 288'(tri_count_out), 288'(16'd2));
    send(1'b0, 16'd0, 1'b0);
    chk_head("one.hold", 16'd3, 16'd4, 16'd5);
    send(1'b0, 16'd0, 1'b1);
    chk("one.empty", 288'(valid_out), 288'(1'b0));

    // asynchronous reset with two queued triangles and one partial vertex
    do_reset();
    for (int i = 0; i < 7; i++) send(1'b1, 16'(i), 1'b0);
    chk("mid.cnt_pre", 288'(tri_count_out), 288'(16'd2));
    rst_in = 1'b0;
    #1;
    chk("mid.valid", 288'(valid_out), 288'(1'b0));
    chk("mid.cnt", 288'(tri_count_out), 288'(16'd0));
    chk("mid.ids", 288'(vertex_ids_out), 288'(0));
    chk("mid.pos", 288'(vertices_out), 288'(0));
    chk("mid.col", 288'(colors_out), 288'(0));
    chk("mid.ovf", 288'(overflow_out), 288'(1'b0));
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    send(1'b1, 16'd10, 1'b1);
    send(1'b1, 16'd11, 1'b1);
    chk("mid.no_early", 288'(valid_out), 288'(1'b0));
    send(1'b1, 16'd12, 1'b1);
    chk_head("mid.after", 16'd10, 16'd11, 16'd12);
    chk("mid.cnt_after", 288'(tri_count_out), 288'(16'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/triangle_assemble.md
TRIANGLE_ASSEMBLE -- requirements
Module: triangle_assemble

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the triangle FIFO depth (power of 2, range 2..16).
REQ-002 SHALL have parameter RESTART_ID, default 16'hFFFF, meaning the vertex id that requests primitive restart.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1, vertex stream valid (no backpressure; every valid cycle is a vertex).
REQ-006 SHALL have port vertex_id_in, input, 16, vertex index.
REQ-007 SHALL have port vertex_in, input, [2:0][31:0], vertex x/y/z position.
REQ-008 SHALL have port color_in, input, 12, vertex RGB444 color.
REQ-009 SHALL have port ready_in, input, 1, downstream accepts triangle.
REQ-010 SHALL have port valid_out, output, 1, triangle available at FIFO head.
REQ-011 SHALL have port vertex_ids_out, output, [2:0][15:0], head triangle ids (index 0 = first received).
REQ-012 SHALL have port vertices_out, output, [2:0][2:0][31:0], head triangle positions.
REQ-013 SHALL have port colors_out, output, [2:0][11:0], head triangle colors.
REQ-014 SHALL have port overflow_out, output, 1, sticky: a triangle was dropped.
REQ-015 SHALL have port tri_count_out, output, 16, triangles pushed since reset.

Function
REQ-016 SHALL hold a 2-bit assembly index (0,1,2) plus two vertex slots (id, position, color).
REQ-017 On valid_in with vertex_id_in != RESTART_ID and index 0 or 1: SHALL store the vertex in slot[index] and increment index.
REQ-018 On valid_in with vertex_id_in != RESTART_ID and index 2: SHALL push {slot0, slot1, current vertex} into the FIFO and set index to 0.
REQ-019 On valid_in with vertex_id_in == RESTART_ID: SHALL set index to 0, discard the partial triangle, push nothing.
REQ-020 SHALL ignore all inputs when valid_in=0; index and slots hold.
REQ-021 SHALL present the FIFO head on the data outputs, with valid_out=1 iff the FIFO is non-empty.
REQ-022 Latency: a pushed triangle SHALL appear with valid_out=1 one cycle after the edge on which its third vertex is sampled (FIFO empty case).
REQ-023 SHALL pop on a cycle with valid_out=1 and ready_in=1; the next entry or valid_out=0 follows on the next cycle.
REQ-024 SHALL keep data outputs stable while valid_out=1 and ready_in=0.
REQ-025 Push while full without a pop SHALL drop the new triangle, set overflow_out=1, and leave tri_count_out unchanged.
REQ-026 Push and pop in the same cycle while full SHALL accept both, with no overflow.
REQ-027 Push and pop in the same cycle while holding 1 entry SHALL leave occupancy 1, with the new triangle at the head next cycle.
REQ-028 overflow_out SHALL stay 1 until reset.
REQ-029 tri_count_out SHALL increment by 1 per accepted push and wrap from 16'hFFFF to 0.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy count.

Reset
REQ-031 While rst_in=0, SHALL asynchronously clear: index=0, FIFO empty, valid_out=0, overflow_out=0, tri_count_out=0, data outputs and slots all 0.
REQ-032 Reset mid-triangle or with the FIFO non-empty SHALL discard all partial and queued triangles.
REQ-033 The first vertex after reset release SHALL be stored at index 0.

Verification
REQ-034 SHALL test basic assembly: ready_in=1; ids 0,1,2 with positions/colors distinct on consecutive cycles -> valid_out=1 for exactly one cycle, one cycle after id 2; vertex_ids_out={2,1,0}; tri_count_out=1.
REQ-035 SHALL test restart: ids 5,6,FFFF,7,8,9 -> exactly one triangle, vertex_ids_out={9,8,7}.
REQ-036 SHALL test backpressure/overflow with FIFO_DEPTH=4, ready_in=0: 15 vertices (ids 0..14) -> 4 triangles queued, fifth dropped, overflow_out=1, tri_count_out=4; then ready_in=1 -> heads {2,1,0},{5,4,3},{8,7,6},{11,10,9} in order, then valid_out=0.
REQ-037 SHALL test full with simultaneous pop: FIFO full, ready_in=1 on the same cycle the third vertex arrives -> no overflow, tri_count_out=5.
REQ-038 SHALL test reset: assert rst_in=0 after vertex 1 of a triangle with 2 queued -> all outputs 0 immediately; after release, ids 10,11,12 -> vertex_ids_out={12,11,10}.
